pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage, succeeding the two-input PC mux. It holds the fetch PC register and selects the next PC from sequential, branch, jump and trap sources by fixed priority. A stall input freezes the PC, and a one-entry pending-redirect buffer keeps any redirect that arrives while the PC is stalled. It sits between the execute/exception logic and the instruction memory address port.

## Interface
- XLEN, 32: PC and target width.
- INSTR_BYTES, 4: sequential increment; power of two, 1..8.
- RESET_VECTOR, 32'h0040_0000: PC value in reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hold the PC this cycle.
- branch_taken  in  1  branch redirect request.
- branch_target  in  XLEN  branch target.
- jump_valid  in  1  jump redirect request.
- jump_target  in  XLEN  jump target.
- trap_valid  in  1  trap redirect request.
- trap_vector  in  XLEN  trap handler address.
- pc  out  XLEN  registered fetch PC.
- pc_next_seq  out  XLEN  pc + INSTR_BYTES, combinational.
- fetch_valid  out  1  registered; pc is a real fetch address.
- redirect_pending  out  1  registered; the pending buffer is occupied.
- misalign  out  1  registered one-cycle pulse: the accepted target had nonzero low bits.
- pc_src  out  3  registered source of the current pc (pc_src_e).

## Operation
- FSM states: S_BOOT, S_RUN, S_PEND.
- Reset (asynchronous): pc=RESET_VECTOR, state=S_BOOT, fetch_valid=0, redirect_pending=0, misalign=0, pc_src=PC_SRC_RESET, pending buffer cleared. Reset applied mid-operation drops any pending redirect.
- S_BOOT: all inputs, including stall, are ignored. On the first edge after rst_n rises: go to S_RUN, pc unchanged, fetch_valid=1.
- S_RUN, stall=0: pc is loaded from the highest-priority source.
  - Priority: trap, then jump, then branch, then sequential.
- S_RUN, stall=1, any redirect present: pc holds. The winning target and its is_trap flag go into the pending buffer. Next state is S_PEND.
- S_RUN, stall=1, no redirect: pc holds; state stays S_RUN.
- S_PEND, stall=1: pc holds. A new redirect overwrites the buffer, with one exception: a non-trap redirect never replaces a pending trap.
- S_PEND, stall=0: pc is loaded by this priority:
  1. trap_valid
  2. pending trap
  3. jump
  4. branch
  5. pending non-trap
  
  The buffer then clears and the state returns to S_RUN. The pending entry is always consumed, even when a live redirect wins.
- Alignment: every loaded target has its low log2(INSTR_BYTES) bits cleared. If those cleared bits were nonzero, misalign pulses for one cycle together with the pc update.
- Arithmetic: pc_next_seq wraps modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirects that are lost when their source deasserts during a stall without being captured are the requester's responsibility. The block captures only what is present while stall is high.

## Timing
- Redirect latency: a request sampled at edge N with stall=0 appears on pc after edge N; one cycle.
- Stalled redirect: appears on pc after the first edge with stall=0.
- pc, fetch_valid, redirect_pending, misalign and pc_src all change only on a clock edge or on reset.
- pc_next_seq follows pc combinationally.
- Simultaneous trap, jump and branch: trap wins. The others are dropped and are not buffered.
- Back-to-back redirects without stall: each one is accepted in the cycle it is presented.

## Structure
- Package pc_pkg holds:
  - pc_src_e: PC_SRC_RESET, PC_SRC_SEQ, PC_SRC_BRANCH, PC_SRC_JUMP, PC_SRC_TRAP, PC_SRC_PEND.
  - pc_state_e: S_BOOT, S_RUN, S_PEND.
  - An alignment-mask function of XLEN and INSTR_BYTES.
- Sub-module pc_next_sel: combinational priority selector (the generalised PC mux). It returns the target, pc_src and a misalign flag.
- pc_gen holds the PC register, the FSM and the pending buffer.

## Test plan
- Reset release, no stimulus: pc=0040_0000, fetch_valid=0. After the 1st edge fetch_valid=1 and pc still 0040_0000. After the 2nd edge pc=0040_0004 with pc_src=SEQ.
- branch_taken=1 with target 0040_0080, stall=0: the next pc is 0040_0080. Simultaneous jump_valid to 0040_1000 instead gives 0040_1000.
- stall=1 with branch to 0040_0200: redirect_pending=1 and pc held. On release pc=0040_0200, pc_src=PC_SRC_PEND, redirect_pending=0.
- While stalled, trap to 8000_0000 followed by jump to 0040_0300: the buffer keeps the trap. On release pc=8000_0000.
- jump_target 0040_0102: pc=0040_0100 and misalign pulses for exactly one cycle. pc=FFFF_FFFC sequential: the next pc is 0000_0000.
- rst_n driven low mid-cycle while in S_PEND: pc=0040_0000, redirect_pending=0, fetch_valid=0 immediately. After release the pending target is never loaded.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and the alignment-mask helper for the fetch PC generator
package pc_pkg;
  typedef enum logic [2:0] {
    PC_SRC_RESET,
    PC_SRC_SEQ,
    PC_SRC_BRANCH,
    PC_SRC_JUMP,
    PC_SRC_TRAP,
    PC_SRC_PEND
  } pc_src_e;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND} pc_state_e;
  // Ones above the instruction-alignment bits, limited to xlen bits (xlen <= 64).
  function automatic logic [63:0] align_mask(input int xlen, input int instr_bytes);
    logic [63:0] m;
    m = ~64'(instr_bytes - 1);
    return xlen >= 64 ? m : m & ((64'd1 << xlen) - 64'd1);
  endfunction
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC bus between execute/exception logic (master) and pc_gen (slave)
//   master drives stall and the branch/jump/trap redirect requests;
//   slave returns pc, pc_next_seq, fetch_valid, redirect_pending, misalign, pc_src.
interface pc_gen_if import pc_pkg::*; #(parameter int XLEN = 32) ();
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump_valid;
  logic [XLEN-1:0] jump_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic            fetch_valid;
  logic            redirect_pending;
  logic            misalign;
  pc_src_e         pc_src;
  modport master (
    output stall, branch_taken, branch_target, jump_valid, jump_target, trap_valid, trap_vector,
    input  pc, pc_next_seq, fetch_valid, redirect_pending, misalign, pc_src
  );
  modport slave (
    input  stall, branch_taken, branch_target, jump_valid, jump_target, trap_valid, trap_vector,
    output pc, pc_next_seq, fetch_valid, redirect_pending, misalign, pc_src
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority selector for the next PC (trap, pending trap, jump, branch, pending, sequential)
//   in : pc_seq, live redirects, pending buffer entry
//   out: raw (unaligned winner), target (aligned), src, misalign, redir (non-sequential winner), is_trap
module pc_next_sel import pc_pkg::*; #(
  parameter int XLEN = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic [XLEN-1:0] pc_seq,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            pend_valid,
  input  logic            pend_trap,
  input  logic [XLEN-1:0] pend_target,
  output logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] target,
  output pc_src_e         src,
  output logic            misalign,
  output logic            redir,
  output logic            is_trap
);
  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(XLEN, INSTR_BYTES));
  logic pend_t;
  always_comb begin
    pend_t = pend_valid && pend_trap;
    raw = trap_valid ? trap_vector : pend_t ? pend_target : jump_valid ? jump_target :
          branch_taken ? branch_target : pend_valid ? pend_target : pc_seq;
    src = trap_valid ? PC_SRC_TRAP : pend_t ? PC_SRC_PEND : jump_valid ? PC_SRC_JUMP :
          branch_taken ? PC_SRC_BRANCH : pend_valid ? PC_SRC_PEND : PC_SRC_SEQ;
    redir = trap_valid || jump_valid || branch_taken || pend_valid;
    is_trap = trap_valid || pend_t;
    target = redir ? raw & MASK : raw;
    misalign = redir && |(raw & ~MASK);
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with boot/run/pending FSM and a one-entry stalled-redirect buffer
//   clk, rst_n (async, active-low); bus: pc_gen_if slave (stall + redirects in, pc/status out)
module pc_gen import pc_pkg::*; #(
  parameter int XLEN = 32,
  parameter int INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0040_0000
) (
  input logic       clk,
  input logic       rst_n,
  pc_gen_if.slave   bus
);
  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_target_q, pend_target_d, pc_seq;
  logic            fetch_valid_q, fetch_valid_d, misalign_q, misalign_d;
  logic            pend_valid_q, pend_valid_d, pend_trap_q, pend_trap_d;
  pc_src_e         pc_src_q, pc_src_d;
  logic [XLEN-1:0] sel_raw, sel_target;
  pc_src_e         sel_src;
  logic            sel_mis, sel_redir, sel_trap, run, load, cap;
  assign pc_seq = pc_q + XLEN'(INSTR_BYTES);
  pc_next_sel #(.XLEN(XLEN), .INSTR_BYTES(INSTR_BYTES)) u_sel (
    .pc_seq        (pc_seq),
    .trap_valid    (bus.trap_valid),
    .trap_vector   (bus.trap_vector),
    .jump_valid    (bus.jump_valid),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .pend_valid    (pend_valid_q),
    .pend_trap     (pend_trap_q),
    .pend_target   (pend_target_q),
    .raw           (sel_raw),
    .target        (sel_target),
    .src           (sel_src),
    .misalign      (sel_mis),
    .redir         (sel_redir),
    .is_trap       (sel_trap)
  );
  // While stalled the selector already folds in the pending entry, so re-capturing its
  // winner implements both overwrite and "a pending trap is never replaced by a non-trap".
  always_comb begin
    run = state_q != S_BOOT;
    load = run && !bus.stall;
    cap = run && bus.stall && sel_redir;
    state_d = cap ? S_PEND : S_RUN;
    pc_d = load ? sel_target : pc_q;
    pc_src_d = load ? sel_src : pc_src_q;
    misalign_d = load && sel_mis;
    fetch_valid_d = 1'b1;
    pend_valid_d = cap;
    pend_trap_d = cap ? sel_trap : 1'b0;
    pend_target_d = cap ? sel_raw : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q <= RESET_VECTOR;
      pc_src_q <= PC_SRC_RESET;
      fetch_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pc_src_q <= pc_src_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q <= misalign_d;
      pend_valid_q <= pend_valid_d;
      pend_trap_q <= pend_trap_d;
      pend_target_q <= pend_target_d;
    end
  end
  assign bus.pc = pc_q;
  assign bus.pc_next_seq = pc_seq;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.redirect_pending = pend_valid_q;
  assign bus.misalign = misalign_q;
  assign bus.pc_src = pc_src_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen
module tb_pc_gen;
  import pc_pkg::*;
  typedef struct {
    logic [31:0] pc;
    pc_src_e     src;
    logic        fv;
    logic        rp;
    logic        mis;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  pc_gen_if #(.XLEN(32)) pcif ();
  pc_gen #(.XLEN(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0040_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pcif.slave)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic check_now(input string tag);
    exp_t e;
    vectors++;
    assert (q.size() > 0) else begin
      miscompares++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp({tag, ".pc"}, pcif.pc, e.pc);
      cmp({tag, ".src"}, 32'(pcif.pc_src), 32'(e.src));
      cmp({tag, ".fv"}, 32'(pcif.fetch_valid), 32'(e.fv));
      cmp({tag, ".rp"}, 32'(pcif.redirect_pending), 32'(e.rp));
      cmp({tag, ".mis"}, 32'(pcif.misalign), 32'(e.mis));
    end
  endtask
  task automatic expect_push(input logic [31:0] pc, input pc_src_e src, input logic fv, rp, mis);
    exp_t e;
    e.pc = pc; e.src = src; e.fv = fv; e.rp = rp; e.mis = mis;
    q.push_back(e);
  endtask
  task automatic step(input string tag, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic jv, input logic [31:0] jt,
                      input logic tv, input logic [31:0] tt,
                      input logic [31:0] epc, input pc_src_e esrc, input logic erp, input logic emis);
    pcif.stall = st;
    pcif.branch_taken = br; pcif.branch_target = bt;
    pcif.jump_valid = jv; pcif.jump_target = jt;
    pcif.trap_valid = tv; pcif.trap_vector = tt;
    expect_push(epc, esrc, 1'b1, erp, emis);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask
  initial begin
    pcif.stall = 1'b0;
    pcif.branch_taken = 1'b0; pcif.branch_target = '0;
    pcif.jump_valid = 1'b0; pcif.jump_target = '0;
    pcif.trap_valid = 1'b0; pcif.trap_vector = '0;
    #12;
    expect_push(32'h0040_0000, PC_SRC_RESET, 1'b0, 1'b0, 1'b0);
    check_now("reset");
    #5 rst_n = 1'b1;
    step("boot",      0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, PC_SRC_RESET, 0, 0);
    step("seq1",      0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, PC_SRC_SEQ, 0, 0);
    step("branch",    0, 1, 32'h0040_0080, 0, 0, 0, 0, 32'h0040_0080, PC_SRC_BRANCH, 0, 0);
    step("jmp_vs_br", 0, 1, 32'h0040_0100, 1, 32'h0040_1000, 0, 0, 32'h0040_1000, PC_SRC_JUMP, 0, 0);
    step("stall_br",  1, 1, 32'h0040_0200, 0, 0, 0, 0, 32'h0040_1000, PC_SRC_JUMP, 1, 0);
    step("stall_hold",1, 0, 0, 0, 0, 0, 0, 32'h0040_1000, PC_SRC_JUMP, 1, 0);
    step("pend_rel",  0, 0, 0, 0, 0, 0, 0, 32'h0040_0200, PC_SRC_PEND, 0, 0);
    step("stall_trap",1, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h0040_0200, PC_SRC_PEND, 1, 0);
    step("stall_jmp", 1, 0, 0, 1, 32'h0040_0300, 0, 0, 32'h0040_0200, PC_SRC_PEND, 1, 0);
    step("trap_kept", 0, 0, 0, 0, 0, 0, 0, 32'h8000_0000, PC_SRC_PEND, 0, 0);
    step("seq2",      0, 0, 0, 0, 0, 0, 0, 32'h8000_0004, PC_SRC_SEQ, 0, 0);
    step("mis_jmp",   0, 0, 0, 1, 32'h0040_0102, 0, 0, 32'h0040_0100, PC_SRC_JUMP, 0, 1);
    step("mis_clear", 0, 0, 0, 0, 0, 0, 0, 32'h0040_0104, PC_SRC_SEQ, 0, 0);
    step("all_three", 0, 1, 32'h0040_0500, 1, 32'h0040_0600, 1, 32'h0000_0010, 32'h0000_0010, PC_SRC_TRAP, 0, 0);
    step("dropped",   0, 0, 0, 0, 0, 0, 0, 32'h0000_0014, PC_SRC_SEQ, 0, 0);
    step("trap_top",  0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, PC_SRC_TRAP, 0, 0);
    cmp("next_seq_wrap", pcif.pc_next_seq, 32'h0000_0000);
    step("wrap",      0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, PC_SRC_SEQ, 0, 0);
    cmp("next_seq", pcif.pc_next_seq, 32'h0000_0004);
    step("stall_none",1, 0, 0, 0, 0, 0, 0, 32'h0000_0000, PC_SRC_SEQ, 0, 0);
    step("stall_br2", 1, 1, 32'h0040_0040, 0, 0, 0, 0, 32'h0000_0000, PC_SRC_SEQ, 1, 0);
    step("live_jmp",  0, 0, 0, 1, 32'h0040_0500, 0, 0, 32'h0040_0500, PC_SRC_JUMP, 0, 0);
    step("consumed",  0, 0, 0, 0, 0, 0, 0, 32'h0040_0504, PC_SRC_SEQ, 0, 0);
    step("stall_misb",1, 1, 32'h0040_0203, 0, 0, 0, 0, 32'h0040_0504, PC_SRC_SEQ, 1, 0);
    step("pend_mis",  0, 0, 0, 0, 0, 0, 0, 32'h0040_0200, PC_SRC_PEND, 0, 1);
    step("pend_mis0", 0, 0, 0, 0, 0, 0, 0, 32'h0040_0204, PC_SRC_SEQ, 0, 0);
    step("stall_trp2",1, 0, 0, 0, 0, 1, 32'h0000_0100, 32'h0040_0204, PC_SRC_SEQ, 1, 0);
    step("ptrap_win", 0, 0, 0, 1, 32'h0040_0600, 0, 0, 32'h0000_0100, PC_SRC_PEND, 0, 0);
    step("stall_br3", 1, 1, 32'h0040_0700, 0, 0, 0, 0, 32'h0000_0100, PC_SRC_PEND, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    expect_push(32'h0040_0000, PC_SRC_RESET, 1'b0, 1'b0, 1'b0);
    check_now("async_rst");
    #3;
    pcif.branch_taken = 1'b0;
    rst_n = 1'b1;
    step("boot2_stall",1, 1, 32'h0040_0900, 0, 0, 0, 0, 32'h0040_0000, PC_SRC_RESET, 0, 0);
    step("no_stale",  0, 0, 0, 0, 0, 0, 0, 32'h0040_0004, PC_SRC_SEQ, 0, 0);
    step("seq3",      0, 0, 0, 0, 0, 0, 0, 32'h0040_0008, PC_SRC_SEQ, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
